// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - instruction fetch: PC register, next-PC select, IF/ID register (optional counter: REDIRECT_CNT_EN)
module fetch_pc_ctrl #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [31:0]      br_pc,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [INS_W-1:0] ifid_instr,
    output logic             ifid_valid,
    output logic             flush_idex,
    output logic [31:0]      redirect_cnt
);

    localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [PC_W-1:0]   pc, pc_d;
    logic [PC_W-1:0]   ifid_pc_d;
    logic [INS_W-1:0]  ifid_instr_d;
    logic              ifid_valid_d;
    logic              flush_d;
    logic              redirect;
    logic [PC_W-1:0]   br_target;
    logic              unused_br_bits;

    // Redirect target keeps only the PC-width byte address, word aligned
    assign br_target      = {br_pc[PC_W-1:2], 2'b00};
    assign unused_br_bits = ^{br_pc[31:PC_W], br_pc[1:0]};
    assign imem_addr      = pc;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_d;
        end
    end

    // Next state, next PC and next IF/ID contents; redirect beats stall, BOOT ignores both
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        ifid_pc_d    = ifid_pc;
        ifid_instr_d = ifid_instr;
        ifid_valid_d = ifid_valid;
        flush_d      = 1'b0;
        redirect     = 1'b0;
        case (state)
            BOOT: begin
                state_d = RUN;
            end
            RUN, REDIR: begin
                state_d = RUN;
                if (pc_sel) begin
                    redirect     = 1'b1;
                    pc_d         = br_target;
                    ifid_pc_d    = '0;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                    flush_d      = 1'b1;
                    state_d      = REDIR;
                end else if (!stall) begin
                    pc_d         = pc + PC_W'(4);
                    ifid_pc_d    = pc;
                    ifid_instr_d = imem_rdata;
                    ifid_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // PC, IF/ID pipeline register and ID/EX squash pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            ifid_pc    <= '0;
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
            flush_idex <= 1'b0;
        end else begin
            pc         <= pc_d;
            ifid_pc    <= ifid_pc_d;
            ifid_instr <= ifid_instr_d;
            ifid_valid <= ifid_valid_d;
            flush_idex <= flush_d;
        end
    end

`ifdef REDIRECT_CNT_EN
    logic [31:0] cnt;

    // Count taken redirects outside BOOT, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (redirect) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign redirect_cnt = cnt;
`else
    logic unused_redirect;

    assign unused_redirect = redirect;
    assign redirect_cnt    = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        pc_sel;
    logic [31:0] br_pc;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [8:0]  ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        flush_idex;
    logic [31:0] redirect_cnt;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // instruction memory model: data encodes its own address
    function automatic logic [31:0] mem(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'h0, a};
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_pc_ctrl #(.PC_W(9), .INS_W(32), .RESET_PC(9'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .br_pc(br_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .flush_idex(flush_idex),
        .redirect_cnt(redirect_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; pc_sel = 1'b0; br_pc = 32'h0;
        step(); step();
        tests++; if (imem_addr !== 9'h0) begin failed++; $display("FAIL rst_addr got %h exp %h", imem_addr, 9'h0); end
        tests++; if (ifid_instr !== 32'h13) begin failed++; $display("FAIL rst_instr got %h exp %h", ifid_instr, 32'h13); end
        tests++; if (ifid_valid !== 1'b0 || flush_idex !== 1'b0 || ifid_pc !== 9'h0) begin failed++; $display("FAIL rst_ctrl got v=%b f=%b pc=%h exp 0 0 0", ifid_valid, flush_idex, ifid_pc); end
        tests++; if (redirect_cnt !== 32'h0) begin failed++; $display("FAIL rst_cnt got %h exp 0", redirect_cnt); end
        reset = 1'b0;
        // BOOT cycle
        tests++; if (imem_addr !== 9'h0 || ifid_valid !== 1'b0) begin failed++; $display("FAIL boot got addr=%h v=%b exp 0 0", imem_addr, ifid_valid); end
        step();
        tests++; if (imem_addr !== 9'h0 || ifid_valid !== 1'b0) begin failed++; $display("FAIL run0 got addr=%h v=%b exp 0 0", imem_addr, ifid_valid); end
        step();
        tests++; if (imem_addr !== 9'h4 || ifid_valid !== 1'b1 || ifid_pc !== 9'h0 || ifid_instr !== mem(9'h0)) begin failed++; $display("FAIL first_fetch got addr=%h v=%b pc=%h ins=%h exp 004 1 000 %h", imem_addr, ifid_valid, ifid_pc, ifid_instr, mem(9'h0)); end
        step();
        tests++; if (imem_addr !== 9'h8 || ifid_pc !== 9'h4) begin failed++; $display("FAIL second_fetch got addr=%h pc=%h exp 008 004", imem_addr, ifid_pc); end
    endtask

    task automatic test_redirect();
        step(); step();
        tests++; if (imem_addr !== 9'h10) begin failed++; $display("FAIL pre_redir got %h exp 010", imem_addr); end
        pc_sel = 1'b1; br_pc = 32'h40;
        step();
        pc_sel = 1'b0;
        tests++; if (imem_addr !== 9'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || ifid_pc !== 9'h0 || flush_idex !== 1'b1) begin failed++; $display("FAIL redir got addr=%h v=%b ins=%h pc=%h f=%b exp 040 0 13 000 1", imem_addr, ifid_valid, ifid_instr, ifid_pc, flush_idex); end
        step();
        tests++; if (imem_addr !== 9'h44 || ifid_valid !== 1'b1 || ifid_pc !== 9'h40 || ifid_instr !== mem(9'h40) || flush_idex !== 1'b0) begin failed++; $display("FAIL redir_target got addr=%h v=%b pc=%h ins=%h f=%b exp 044 1 040 %h 0", imem_addr, ifid_valid, ifid_pc, ifid_instr, flush_idex, mem(9'h40)); end
    endtask

    task automatic test_stall();
        pc_sel = 1'b1; br_pc = 32'h1C;
        step();
        pc_sel = 1'b0;
        step();
        tests++; if (imem_addr !== 9'h20 || ifid_pc !== 9'h1C) begin failed++; $display("FAIL pre_stall got addr=%h pc=%h exp 020 01c", imem_addr, ifid_pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (imem_addr !== 9'h20 || ifid_pc !== 9'h1C || ifid_instr !== mem(9'h1C) || ifid_valid !== 1'b1 || flush_idex !== 1'b0) begin failed++; $display("FAIL stall%0d got addr=%h pc=%h ins=%h v=%b f=%b exp 020 01c %h 1 0", i, imem_addr, ifid_pc, ifid_instr, ifid_valid, flush_idex, mem(9'h1C)); end
        end
        stall = 1'b0;
        step();
        tests++; if (imem_addr !== 9'h24 || ifid_pc !== 9'h20 || ifid_instr !== mem(9'h20)) begin failed++; $display("FAIL resume got addr=%h pc=%h ins=%h exp 024 020 %h", imem_addr, ifid_pc, ifid_instr, mem(9'h20)); end
    endtask

    task automatic test_stall_and_redirect();
        stall = 1'b1; pc_sel = 1'b1; br_pc = 32'h1F3;
        step();
        pc_sel = 1'b0;
        tests++; if (imem_addr !== 9'h1F0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || ifid_pc !== 9'h0 || flush_idex !== 1'b1) begin failed++; $display("FAIL stall_redir got addr=%h v=%b ins=%h pc=%h f=%b exp 1f0 0 13 000 1", imem_addr, ifid_valid, ifid_instr, ifid_pc, flush_idex); end
        step();
        tests++; if (imem_addr !== 9'h1F0 || ifid_valid !== 1'b0 || flush_idex !== 1'b0) begin failed++; $display("FAIL redir_stall_hold got addr=%h v=%b f=%b exp 1f0 0 0", imem_addr, ifid_valid, flush_idex); end
        stall = 1'b0;
        step();
        tests++; if (imem_addr !== 9'h1F4 || ifid_valid !== 1'b1 || ifid_pc !== 9'h1F0) begin failed++; $display("FAIL stall_redir_target got addr=%h v=%b pc=%h exp 1f4 1 1f0", imem_addr, ifid_valid, ifid_pc); end
    endtask

    task automatic test_wrap();
        step(); step();
        tests++; if (imem_addr !== 9'h1FC) begin failed++; $display("FAIL pre_wrap got %h exp 1fc", imem_addr); end
        step();
        tests++; if (imem_addr !== 9'h000 || ifid_pc !== 9'h1FC || ifid_instr !== mem(9'h1FC)) begin failed++; $display("FAIL wrap got addr=%h pc=%h ins=%h exp 000 1fc %h", imem_addr, ifid_pc, ifid_instr, mem(9'h1FC)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        // BOOT: pc_sel must be ignored
        pc_sel = 1'b1; br_pc = 32'h80;
        step();
        pc_sel = 1'b0;
        tests++; if (imem_addr !== 9'h0 || flush_idex !== 1'b0 || redirect_cnt !== 32'h0) begin failed++; $display("FAIL boot_pc_sel got addr=%h f=%b cnt=%0d exp 000 0 0", imem_addr, flush_idex, redirect_cnt); end
        pc_sel = 1'b1; br_pc = 32'h100;
        step();
        tests++; if (imem_addr !== 9'h100 || flush_idex !== 1'b1) begin failed++; $display("FAIL b2b_first got addr=%h f=%b exp 100 1", imem_addr, flush_idex); end
        br_pc = 32'h140;
        step();
        pc_sel = 1'b0;
`ifdef REDIRECT_CNT_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        tests++; if (imem_addr !== 9'h140 || flush_idex !== 1'b1 || ifid_valid !== 1'b0) begin failed++; $display("FAIL b2b_second got addr=%h f=%b v=%b exp 140 1 0", imem_addr, flush_idex, ifid_valid); end
        tests++; if (redirect_cnt !== exp_cnt) begin failed++; $display("FAIL redirect_cnt got %0d exp %0d", redirect_cnt, exp_cnt); end
        step();
        tests++; if (imem_addr !== 9'h144 || ifid_pc !== 9'h140 || ifid_valid !== 1'b1 || flush_idex !== 1'b0) begin failed++; $display("FAIL b2b_target got addr=%h pc=%h v=%b f=%b exp 144 140 1 0", imem_addr, ifid_pc, ifid_valid, flush_idex); end
    endtask

    task automatic test_async_reset();
        pc_sel = 1'b1; br_pc = 32'h60;
        step();
        pc_sel = 1'b0;
        tests++; if (flush_idex !== 1'b1 || imem_addr !== 9'h60) begin failed++; $display("FAIL pre_areset got f=%b addr=%h exp 1 060", flush_idex, imem_addr); end
        #2 reset = 1'b1;
        #1;
        tests++; if (imem_addr !== 9'h0 || flush_idex !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || ifid_pc !== 9'h0 || redirect_cnt !== 32'h0) begin failed++; $display("FAIL areset got addr=%h f=%b v=%b ins=%h pc=%h cnt=%0d exp 000 0 0 13 000 0", imem_addr, flush_idex, ifid_valid, ifid_instr, ifid_pc, redirect_cnt); end
        step();
        reset = 1'b0;
        step();
        tests++; if (imem_addr !== 9'h0 || ifid_valid !== 1'b0) begin failed++; $display("FAIL areset_boot got addr=%h v=%b exp 000 0", imem_addr, ifid_valid); end
        step();
        tests++; if (imem_addr !== 9'h4 || ifid_valid !== 1'b1 || ifid_pc !== 9'h0) begin failed++; $display("FAIL areset_run got addr=%h v=%b pc=%h exp 004 1 000", imem_addr, ifid_valid, ifid_pc); end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_stall();
        test_stall_and_redirect();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
